// File: rtl/payload_ingress_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : payload_ingress_writer                                           |
// | Brief   : Writes an ingress word stream into the payload buffer one node   |
// |           per word, then emits one descriptor per packet.                  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module payload_ingress_writer #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 10,
   parameter int TTL_W     = 4,
   parameter int COUNT_W   = 12,
   parameter int MAX_NODES = 64
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_W-1:0]           in_data,
   input  logic                        in_last,
   input  logic [$clog2(DATA_W/8):0]   in_bytes,
   input  logic [TTL_W-1:0]            in_ttl,
   input  logic                        pb_full,
   output logic                        pb_enable,
   output logic                        pb_read_write,
   output logic [DATA_W-1:0]           pb_wr_data,
   output logic                        pb_wr_is_last,
   output logic [TTL_W-1:0]            pb_wr_ttl,
   output logic [COUNT_W-1:0]          pb_wr_byte_count,
   input  logic [ADDR_W-1:0]           pb_wr_address,
   output logic                        desc_valid,
   input  logic                        desc_ready,
   output logic [ADDR_W-1:0]           desc_address,
   output logic [COUNT_W-1:0]          desc_byte_count,
   output logic [TTL_W-1:0]            desc_ttl,
   output logic                        desc_truncated
);

   localparam int c_BYTES  = DATA_W / 8;
   localparam int c_NCNT_W = $clog2(MAX_NODES + 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_BODY = 3'd1,
      ST_DROP = 3'd2,
      ST_ADDR = 3'd3,
      ST_DESC = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic                  w_in_ready;
   logic                  w_accept;
   logic                  w_write;
   logic                  w_trunc;
   logic                  w_desc_load;
   logic [c_NCNT_W-1:0]   w_node_idx;
   logic [COUNT_W-1:0]    w_eff;
   logic [COUNT_W-1:0]    w_byte_count;

   logic [c_NCNT_W-1:0]   r_node_count;
   logic [TTL_W-1:0]      r_ttl;
   logic                  r_trunc;
   logic                  r_addr_cyc;
   logic                  r_addr_ok;
   logic [ADDR_W-1:0]     r_head_addr;

   logic                  r_pb_enable;
   logic [DATA_W-1:0]     r_pb_wr_data;
   logic                  r_pb_wr_is_last;
   logic [TTL_W-1:0]      r_pb_wr_ttl;
   logic [COUNT_W-1:0]    r_pb_wr_byte_count;

   logic                  r_desc_valid;
   logic [ADDR_W-1:0]     r_desc_address;
   logic [COUNT_W-1:0]    r_desc_byte_count;
   logic [TTL_W-1:0]      r_desc_ttl;
   logic                  r_desc_truncated;

   always_comb begin
      w_state_nxt = r_state;
      w_desc_load = 1'b0;
      case (r_state)
         ST_IDLE, ST_BODY: w_in_ready = ~pb_full;
         ST_DROP:          w_in_ready = 1'b1;
         default:          w_in_ready = 1'b0;
      endcase
      if (reset) begin
         w_in_ready = 1'b0;
      end
      w_accept     = in_valid & w_in_ready;
      w_write      = w_accept & ((r_state == ST_IDLE) | (r_state == ST_BODY));
      w_node_idx   = (r_state == ST_IDLE) ? c_NCNT_W'(1) : r_node_count + c_NCNT_W'(1);
      w_trunc      = w_write & ~in_last & (w_node_idx == c_NCNT_W'(MAX_NODES));
      // A truncated packet ends on a full word regardless of in_bytes.
      w_eff        = (w_trunc || (in_bytes == '0)) ? COUNT_W'(c_BYTES) : COUNT_W'(in_bytes);
      w_byte_count = COUNT_W'(w_node_idx - c_NCNT_W'(1)) * COUNT_W'(c_BYTES) + w_eff;

      case (r_state)
         ST_IDLE, ST_BODY: begin
            if (w_write) begin
               if (in_last)      w_state_nxt = ST_ADDR;
               else if (w_trunc) w_state_nxt = ST_DROP;
               else              w_state_nxt = ST_BODY;
            end
         end
         ST_DROP: begin
            if (w_accept && in_last) w_state_nxt = ST_ADDR;
         end
         ST_ADDR: begin
            // Head address is only valid the cycle after the is_last write.
            if (r_addr_cyc || r_addr_ok) begin
               w_state_nxt = ST_DESC;
               w_desc_load = 1'b1;
            end
         end
         ST_DESC: begin
            if (r_desc_valid && desc_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_node_count       <= '0;
         r_ttl              <= '0;
         r_trunc            <= 1'b0;
         r_addr_cyc         <= 1'b0;
         r_addr_ok          <= 1'b0;
         r_head_addr        <= '0;
         r_pb_enable        <= 1'b0;
         r_pb_wr_data       <= '0;
         r_pb_wr_is_last    <= 1'b0;
         r_pb_wr_ttl        <= '0;
         r_pb_wr_byte_count <= '0;
         r_desc_valid       <= 1'b0;
         r_desc_address     <= '0;
         r_desc_byte_count  <= '0;
         r_desc_ttl         <= '0;
         r_desc_truncated   <= 1'b0;
      end else begin
         r_pb_enable <= w_write;
         r_addr_cyc  <= r_pb_enable & r_pb_wr_is_last;
         if (w_write) begin
            r_pb_wr_data       <= in_data;
            r_pb_wr_is_last    <= in_last | w_trunc;
            r_pb_wr_byte_count <= w_byte_count;
            r_pb_wr_ttl        <= (r_state == ST_IDLE) ? in_ttl : r_ttl;
            r_node_count       <= w_node_idx;
         end
         if (w_write && (r_state == ST_IDLE)) begin
            r_ttl <= in_ttl;
         end
         if (w_trunc) begin
            r_trunc <= 1'b1;
         end
         if (r_addr_cyc) begin
            r_head_addr <= pb_wr_address;
            r_addr_ok   <= 1'b1;
         end
         if (w_desc_load) begin
            r_desc_valid      <= 1'b1;
            r_desc_address    <= r_addr_cyc ? pb_wr_address : r_head_addr;
            r_desc_byte_count <= r_pb_wr_byte_count;
            r_desc_ttl        <= r_ttl;
            r_desc_truncated  <= r_trunc;
            r_trunc           <= 1'b0;
            r_addr_ok         <= 1'b0;
         end
         if ((r_state == ST_DESC) && r_desc_valid && desc_ready) begin
            r_desc_valid     <= 1'b0;
            r_desc_truncated <= 1'b0;
         end
      end
   end

   assign in_ready         = w_in_ready;
   assign pb_enable        = r_pb_enable;
   assign pb_read_write    = r_pb_enable;
   assign pb_wr_data       = r_pb_wr_data;
   assign pb_wr_is_last    = r_pb_wr_is_last;
   assign pb_wr_ttl        = r_pb_wr_ttl;
   assign pb_wr_byte_count = r_pb_wr_byte_count;
   assign desc_valid       = r_desc_valid;
   assign desc_address     = r_desc_address;
   assign desc_byte_count  = r_desc_byte_count;
   assign desc_ttl         = r_desc_ttl;
   assign desc_truncated   = r_desc_truncated;

endmodule
`default_nettype wire

// File: tb/tb_payload_ingress_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_payload_ingress_writer                                        |
// | Brief   : Self-checking bench for payload_ingress_writer.                  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_payload_ingress_writer;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 10;
   localparam int TTL_W     = 4;
   localparam int COUNT_W   = 12;
   localparam int MAX_NODES = 64;
   localparam int BYTES     = DATA_W / 8;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [DATA_W-1:0]    in_data = '0;
   logic                 in_last = 1'b0;
   logic [2:0]           in_bytes = '0;
   logic [TTL_W-1:0]     in_ttl = '0;
   logic                 pb_full = 1'b0;
   logic                 pb_enable;
   logic                 pb_read_write;
   logic [DATA_W-1:0]    pb_wr_data;
   logic                 pb_wr_is_last;
   logic [TTL_W-1:0]     pb_wr_ttl;
   logic [COUNT_W-1:0]   pb_wr_byte_count;
   logic [ADDR_W-1:0]    pb_wr_address = '0;
   logic                 desc_valid;
   logic                 desc_ready = 1'b0;
   logic [ADDR_W-1:0]    desc_address;
   logic [COUNT_W-1:0]   desc_byte_count;
   logic [TTL_W-1:0]     desc_ttl;
   logic                 desc_truncated;

   typedef struct packed {
      logic [DATA_W-1:0]  d;
      logic               l;
      logic [TTL_W-1:0]   t;
      logic [COUNT_W-1:0] bc;
      logic               rw;
   } wr_t;

   wr_t                  wr_q[$];
   logic [DATA_W-1:0]    words [0:127];
   logic [ADDR_W-1:0]    cur_addr = '0;
   logic                 last_seen = 1'b0;
   int                   checks = 0;
   int                   errors = 0;

   payload_ingress_writer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TTL_W(TTL_W),
      .COUNT_W(COUNT_W), .MAX_NODES(MAX_NODES)
   ) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .in_bytes(in_bytes), .in_ttl(in_ttl),
      .pb_full(pb_full), .pb_enable(pb_enable), .pb_read_write(pb_read_write),
      .pb_wr_data(pb_wr_data), .pb_wr_is_last(pb_wr_is_last), .pb_wr_ttl(pb_wr_ttl),
      .pb_wr_byte_count(pb_wr_byte_count), .pb_wr_address(pb_wr_address),
      .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_address(desc_address),
      .desc_byte_count(desc_byte_count), .desc_ttl(desc_ttl),
      .desc_truncated(desc_truncated)
   );

   always #5 clock = ~clock;

   // Buffer model: head address valid only in the cycle after the is_last write.
   always @(posedge clock) begin
      #1;
      pb_wr_address = last_seen ? cur_addr : ADDR_W'($urandom);
      last_seen     = pb_enable && pb_wr_is_last;
   end

   always @(negedge clock) begin
      if (pb_enable && !reset)
         wr_q.push_back('{pb_wr_data, pb_wr_is_last, pb_wr_ttl, pb_wr_byte_count, pb_read_write});
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_random(input int n);
      for (int k = 0; k < n; k++) words[k] = $urandom;
   endtask

   task automatic send_packet(input int n, input logic [TTL_W-1:0] ttl, input logic [2:0] lb,
                              input logic [ADDR_W-1:0] addr, input int full_pct,
                              input int burst_at, input int stall, input int abort_at);
      int   i, cyc, burst, nw, exp_bc, bound;
      logic burst_done, trunc;
      wr_t  w;
      cur_addr   = addr;
      i          = 0;
      cyc        = 0;
      burst      = 0;
      burst_done = 1'b0;
      trunc      = (n > MAX_NODES);
      nw         = trunc ? MAX_NODES : n;
      exp_bc     = trunc ? MAX_NODES * BYTES : (n - 1) * BYTES + ((lb == 0) ? BYTES : int'(lb));
      while (i < n && cyc < 4000) begin
         @(negedge clock);
         cyc++;
         if (i == abort_at) begin
            #2;
            reset = 1'b1;
            #1;
            check("reset_pb_outputs",
                  {in_ready, pb_enable, pb_read_write, pb_wr_is_last, pb_wr_ttl, pb_wr_byte_count, pb_wr_data}, '0);
            check("reset_desc_outputs",
                  {desc_valid, desc_address, desc_byte_count, desc_ttl, desc_truncated}, '0);
            in_valid = 1'b0;
            repeat (2) @(negedge clock);
            reset = 1'b0;
            wr_q.delete();
            repeat (6) begin
               @(negedge clock);
               check("no_activity_after_abort", {desc_valid, pb_enable}, '0);
            end
            return;
         end
         if (i == burst_at && !burst_done) begin
            burst      = 3;
            burst_done = 1'b1;
         end
         if (burst > 0) begin
            pb_full  = 1'b1;
            in_valid = 1'b1;
            burst--;
         end else begin
            pb_full  = ($urandom_range(0, 99) < full_pct);
            in_valid = ($urandom_range(0, 3) != 0);
         end
         in_data  = words[i];
         in_last  = (i == n - 1);
         in_bytes = in_last ? lb : 3'($urandom_range(0, 4));
         in_ttl   = (i == 0) ? ttl : TTL_W'($urandom);
         #1;
         check("in_ready", in_ready, (i < MAX_NODES) ? !pb_full : 1'b1);
         if (in_valid && in_ready) i++;
      end
      check("words_accepted", i, n);
      @(negedge clock);
      in_valid = 1'b0;
      pb_full  = 1'b0;
      bound    = 0;
      while (!desc_valid && bound < 20) begin
         check("in_ready_before_desc", in_ready, 1'b0);
         @(negedge clock);
         bound++;
      end
      check("desc_valid", desc_valid, 1'b1);
      check("desc_address", desc_address, addr);
      check("desc_byte_count", desc_byte_count, exp_bc);
      check("desc_ttl", desc_ttl, ttl);
      check("desc_truncated", desc_truncated, trunc);
      repeat (stall) begin
         @(negedge clock);
         check("desc_stable", {desc_valid, desc_address, desc_byte_count, desc_ttl, desc_truncated},
               {1'b1, addr, COUNT_W'(exp_bc), ttl, trunc});
         check("in_ready_desc_stall", in_ready, 1'b0);
      end
      desc_ready = 1'b1;
      @(negedge clock);
      desc_ready = 1'b0;
      check("desc_after_handshake", {desc_valid, desc_truncated}, 2'b00);
      check("in_ready_after_handshake", in_ready, 1'b1);
      check("write_count", wr_q.size(), nw);
      for (int k = 0; k < nw && k < wr_q.size(); k++) begin
         w = wr_q[k];
         check("wr_data", w.d, words[k]);
         check("wr_is_last", w.l, (k == nw - 1));
         check("wr_ttl", w.t, ttl);
         check("wr_read_write", w.rw, 1'b1);
         if (k == nw - 1) check("wr_byte_count", w.bc, exp_bc);
      end
      wr_q.delete();
   endtask

   initial begin
      #1;
      check("reset_state_pb",
            {in_ready, pb_enable, pb_read_write, pb_wr_is_last, pb_wr_ttl, pb_wr_byte_count, pb_wr_data}, '0);
      check("reset_state_desc",
            {desc_valid, desc_address, desc_byte_count, desc_ttl, desc_truncated}, '0);
      repeat (2) @(negedge clock);
      reset = 1'b0;

      words[0] = 100; words[1] = 200; words[2] = 300; words[3] = 400;
      send_packet(4, 4'd1, 3'd3, 10'h005, 0, -1, 0, -1);

      words[0] = 32'hAB;
      send_packet(1, 4'd7, 3'd0, 10'h123, 0, -1, 0, -1);

      fill_random(66);
      send_packet(66, 4'd9, 3'd2, 10'h3FF, 0, -1, 1, -1);

      fill_random(64);
      send_packet(64, 4'd3, 3'd2, 10'h011, 10, -1, 0, -1);

      fill_random(65);
      send_packet(65, 4'd4, 3'd1, 10'h022, 10, -1, 0, -1);

      fill_random(8);
      send_packet(8, 4'd5, 3'd4, 10'h0C0, 0, 3, 0, -1);

      fill_random(5);
      send_packet(5, 4'd6, 3'd1, 10'h1A5, 0, -1, 5, -1);

      fill_random(10);
      send_packet(10, 4'd2, 3'd2, 10'h077, 0, -1, 0, 4);

      fill_random(6);
      send_packet(6, 4'd8, 3'd0, 10'h2B2, 0, -1, 0, -1);

      for (int p = 0; p < 25; p++) begin
         int n;
         n = $urandom_range(1, 70);
         fill_random(n);
         send_packet(n, TTL_W'($urandom), 3'($urandom_range(0, 4)), ADDR_W'($urandom),
                     $urandom_range(0, 40),
                     ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, n - 1)) : -1,
                     $urandom_range(0, 4), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
